// File: rtl/if_fetch_unit.sv
// Instruction fetch: drives the ROM, generates sequential/redirected PCs, and buffers {pc, inst} for decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects enter FAULT instead of silently aligning.
module if_fetch_unit #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INST_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int                 BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              id_ready_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_misalign_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              ce_q;
  logic              misalign_q;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] pc_mem   [BUF_DEPTH];
  logic [INST_W-1:0] inst_mem [BUF_DEPTH];

  logic              redirect, pop, push;
  logic [ADDR_W-1:0] target_aligned;

  assign redirect       = branch_i && (state != IDLE);
  assign pop            = if_valid_o && id_ready_i && !redirect;
  assign push           = !rst && (state == FETCH) && !branch_i &&
                          ((count < CNT_W'(BUF_DEPTH)) || pop);
  assign target_aligned = {branch_target_i[ADDR_W-1:2], 2'b00};

  assign rom_ce_o   = ce_q;
  assign rom_addr_o = pc;
  assign if_valid_o = (count != '0);
  assign if_pc_o    = if_valid_o ? pc_mem[rd_ptr]   : '0;
  assign if_inst_o  = if_valid_o ? inst_mem[rd_ptr] : '0;

`ifdef FETCH_ALIGN_CHECK_EN
  assign if_misalign_o = misalign_q;
`else
  logic unused_tgt_low;
  assign unused_tgt_low = ^branch_target_i[1:0];
  assign if_misalign_o  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= pc;
      inst_mem[wr_ptr] <= rom_inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ce_q       <= 1'b0;
      misalign_q <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          ce_q  <= 1'b1;
        end
        default: begin
          if (branch_i) begin
            pc     <= target_aligned;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (branch_target_i[1:0] != 2'b00) begin
              state      <= FAULT;
              ce_q       <= 1'b0;
              misalign_q <= 1'b1;
            end else begin
              state      <= FETCH;
              ce_q       <= 1'b1;
              misalign_q <= 1'b0;
            end
`else
            state <= FETCH;
            ce_q  <= 1'b1;
`endif
          end else begin
            if (push) begin
              pc     <= pc + ADDR_W'(4);
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
